// File: rtl/periodic_irq_timer.sv
// periodic_irq_timer: N_CH periodic tick/irq channels with overrun flags; ovr_cnt counters when PERIODIC_IRQ_OVERRUN_CNT_EN is defined
module periodic_irq_timer #(
  parameter int N_CH = 2,
  parameter int CNT_W = 16,
  parameter int DEFAULT_TC = 6249
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  tc_we,
  input  logic [$clog2(N_CH):0] tc_sel,
  input  logic [CNT_W-1:0]      tc_wdata,
  input  logic [N_CH-1:0]       irq_ack,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       irq_req,
  output logic                  irq_any,
  output logic [N_CH-1:0]       overrun,
  output logic [4*N_CH-1:0]     ovr_cnt
);
  localparam int SEL_W = $clog2(N_CH) + 1;
  assign irq_any = |irq_req;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, tc;
    logic wr, hit, t, r, o;
    assign wr = tc_we & (tc_sel == SEL_W'(i));
    assign hit = ch_en[i] & ~wr & (cnt == tc);
    assign tick[i] = t;
    assign irq_req[i] = r;
    assign overrun[i] = o;
    always_ff @(posedge clk)
      if (reset) begin
        cnt <= '0;
        tc <= CNT_W'(DEFAULT_TC);
        t <= 1'b0;
        r <= 1'b0;
        o <= 1'b0;
      end else begin
        tc <= wr ? tc_wdata : tc;
        cnt <= (wr | hit | ~ch_en[i]) ? '0 : cnt + CNT_W'(1);
        t <= hit;
        r <= ~irq_ack[i] & (hit | r);
        o <= ~irq_ack[i] & (o | (hit & r));
      end
`ifdef PERIODIC_IRQ_OVERRUN_CNT_EN
    logic [3:0] oc;
    assign ovr_cnt[4*i +: 4] = oc;
    always_ff @(posedge clk)
      if (reset) oc <= 4'd0;
      else oc <= irq_ack[i] ? 4'd0 : (hit & r & (oc != 4'hf)) ? oc + 4'd1 : oc;
`else
    assign ovr_cnt[4*i +: 4] = 4'd0;
`endif
  end
endmodule

// File: tb/tb_periodic_irq_timer.sv
// tb_periodic_irq_timer: randomized + directed check of periodic_irq_timer against a behavioural model
module tb_periodic_irq_timer;
  localparam int N = 2;
  logic clk = 1'b0, reset = 1'b1, tc_we = 1'b0;
  logic [N-1:0] ch_en = '0, irq_ack = '0, tick, irq_req, overrun;
  logic [1:0] tc_sel = '0;
  logic [15:0] tc_wdata = '0;
  logic irq_any;
  logic [4*N-1:0] ovr_cnt;
  int checks = 0, errors = 0;
  bit run_chk = 1'b0;
  periodic_irq_timer dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .tc_we(tc_we), .tc_sel(tc_sel),
    .tc_wdata(tc_wdata), .irq_ack(irq_ack), .tick(tick), .irq_req(irq_req),
    .irq_any(irq_any), .overrun(overrun), .ovr_cnt(ovr_cnt)
  );
  always #5 clk = ~clk;
  int ph [N];
  int tcm [N];
  logic [N-1:0] e_tick, e_irq, e_ovr, m_wr, m_hit;
  logic [4*N-1:0] e_oc;
  always_comb begin
    m_wr = '0;
    m_hit = '0;
    for (int c = 0; c < N; c++) begin
      m_wr[c] = tc_we && (int'(tc_sel) == c);
      m_hit[c] = ch_en[c] && !m_wr[c] && ((ph[c] % (tcm[c] + 1)) == tcm[c]);
    end
  end
  always @(posedge clk)
    for (int c = 0; c < N; c++)
      if (reset) begin
        ph[c] <= 0;
        tcm[c] <= 6249;
        e_tick[c] <= 1'b0;
        e_irq[c] <= 1'b0;
        e_ovr[c] <= 1'b0;
        e_oc[4*c +: 4] <= 4'd0;
      end else begin
        ph[c] <= (m_wr[c] || !ch_en[c]) ? 0 : ph[c] + 1;
        if (m_wr[c]) tcm[c] <= int'(tc_wdata);
        e_tick[c] <= m_hit[c];
        e_irq[c] <= !irq_ack[c] && (m_hit[c] || e_irq[c]);
        e_ovr[c] <= !irq_ack[c] && (e_ovr[c] || (m_hit[c] && e_irq[c]));
`ifdef PERIODIC_IRQ_OVERRUN_CNT_EN
        if (irq_ack[c]) e_oc[4*c +: 4] <= 4'd0;
        else if (m_hit[c] && e_irq[c] && e_oc[4*c +: 4] != 4'hf) e_oc[4*c +: 4] <= e_oc[4*c +: 4] + 4'd1;
`endif
      end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (run_chk) begin
      chk("tick", 32'(tick), 32'(e_tick));
      chk("irq_req", 32'(irq_req), 32'(e_irq));
      chk("irq_any", 32'(irq_any), 32'(|e_irq));
      chk("overrun", 32'(overrun), 32'(e_ovr));
      chk("ovr_cnt", 32'(ovr_cnt), 32'(e_oc));
    end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int nt;
    bit macro_on;
`ifdef PERIODIC_IRQ_OVERRUN_CNT_EN
    macro_on = 1'b1;
`else
    macro_on = 1'b0;
`endif
    wait_n(3);
    run_chk = 1'b1;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_irq", 32'(irq_req), 0);
    reset = 1'b0;
    ch_en = 2'b11;
    wait_n(6249);
    chk("p1_tick_6249", 32'(tick), 0);
    wait_n(1);
    chk("p1_tick_6250", 32'(tick), 32'h3);
    chk("p1_irq_6250", 32'(irq_req), 32'h3);
    wait_n(1);
    chk("p1_tick_6251", 32'(tick), 0);
    chk("p1_irq_6251", 32'(irq_req), 32'h3);
    chk("p1_ovr_6251", 32'(overrun), 0);
    wait_n(6249);
    chk("p1_tick_12500", 32'(tick), 32'h3);
    chk("p1_ovr_12500", 32'(overrun), 32'h3);
    irq_ack = 2'b11;
    wait_n(1);
    chk("p1_ack_irq", 32'(irq_req), 0);
    chk("p1_ack_ovr", 32'(overrun), 0);
    irq_ack = 2'b00;
    tc_we = 1'b1; tc_sel = 2'd1; tc_wdata = 16'd3;
    wait_n(1);
    tc_we = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 12) begin tc_we = 1'b1; tc_sel = 2'd2; tc_wdata = 16'd0; end
      else tc_we = 1'b0;
      wait_n(1);
      chk($sformatf("p3_ch1_tick_k%0d", k), 32'(tick[1]), 32'((k % 4) == 0));
    end
    tc_we = 1'b0;
    irq_ack = 2'b01;
    tc_we = 1'b1; tc_sel = 2'd0; tc_wdata = 16'd3;
    wait_n(1);
    tc_we = 1'b0;
    nt = 0;
    for (int k = 1; k <= 10; k++) begin
      wait_n(1);
      if (tick[0]) nt++;
      chk("p2_irq0_ack", 32'(irq_req[0]), 0);
      chk("p2_ovr0_ack", 32'(overrun[0]), 0);
    end
    chk("p2_tick_count", nt, 2);
    irq_ack = 2'b10;
    tc_we = 1'b1; tc_sel = 2'd1; tc_wdata = 16'd3;
    wait_n(1);
    irq_ack = 2'b00;
    tc_we = 1'b0;
    wait_n(4);
    chk("p5_irq1_t1", 32'(irq_req[1]), 1);
    chk("p5_ovr1_t1", 32'(overrun[1]), 0);
    wait_n(4);
    chk("p5_ovr1_t2", 32'(overrun[1]), 1);
    wait_n(4);
    chk("p5_ovr1_t3", 32'(overrun[1]), 1);
    chk("p5_ocnt1_t3", 32'(ovr_cnt[7:4]), macro_on ? 2 : 0);
    irq_ack = 2'b10;
    wait_n(1);
    irq_ack = 2'b00;
    chk("p5_clr_irq1", 32'(irq_req[1]), 0);
    chk("p5_clr_ovr1", 32'(overrun[1]), 0);
    chk("p5_clr_ocnt1", 32'(ovr_cnt[7:4]), 0);
    for (int k = 0; k < 5000; k++) begin
      reset = ($urandom % 600) == 0;
      for (int c = 0; c < N; c++) begin
        ch_en[c] = ($urandom % 16) != 0;
        irq_ack[c] = (k < 2500) ? (($urandom % 64) == 0) : (($urandom % 6) == 0);
      end
      tc_we = ($urandom % 8) == 0;
      tc_sel = 2'($urandom % 4);
      tc_wdata = 16'($urandom % 8);
      wait_n(1);
    end
    reset = 1'b1; tc_we = 1'b0; irq_ack = '0; ch_en = 2'b11;
    wait_n(1);
    reset = 1'b0;
    wait_n(8250);
    chk("p7_irq0_pre", 32'(irq_req[0]), 1);
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    chk("p7_rst_tick", 32'(tick), 0);
    chk("p7_rst_irq", 32'(irq_req), 0);
    chk("p7_rst_any", 32'(irq_any), 0);
    chk("p7_rst_ovr", 32'(overrun), 0);
    chk("p7_rst_ocnt", 32'(ovr_cnt), 0);
    wait_n(6249);
    chk("p7_tick_6249", 32'(tick[0]), 0);
    wait_n(1);
    chk("p7_tick_6250", 32'(tick[0]), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
